// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter/sequencer that shares one UART transmitter among
//   NUM_REQ byte requesters. It picks a requester starting from a rotating
//   pointer, latches its byte, issues a one-cycle tx_start, waits for tx_done,
//   acknowledges the requester, then idles for one GAP cycle so the acked
//   requester can drop req before the next arbitration.
//
//   Optional feature: define UART_ARB_TIMEOUT_EN to abort a WAIT that lasts
//   TIMEOUT_CYCLES cycles without tx_done (timeout_err pulse, no ack).
//   Without the macro WAIT holds until tx_done and timeout_err is always 0.
//
// Ports
//   clk          system clock, posedge
//   rst          asynchronous active-high reset
//   req          per-requester request level, held until ack
//   req_data     flattened bytes, requester i at [DATA_W*i +: DATA_W]
//   ack          one-hot one-cycle pulse when requester's byte is sent
//   busy         high whenever the sequencer is not IDLE
//   owner        index of the current grantee (valid while busy)
//   tx_start     one-cycle start pulse to the UART transmitter
//   tx_data      latched byte, stable from tx_start until tx_done
//   tx_busy      transmitter busy level
//   tx_done      transmitter completion pulse
//   timeout_err  one-cycle pulse on WAIT timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int OW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [OW-1:0]             owner,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic                      timeout_err
);

  if (NUM_REQ < 1 || DATA_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ, DATA_W and TIMEOUT_CYCLES must all be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t              state_r;
  logic [OW-1:0]       ptr_r;
  logic [OW-1:0]       cand_s;
  logic [OW-1:0]       pick_s;
  logic                found_s;
  logic                hit_s;
  logic [DATA_W-1:0]   pick_data_s;
  logic [OW-1:0]       nxt_ptr_s;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]       wait_cnt_r;
`endif

  // Round-robin pick: first requesting index scanning ptr, ptr+1, ... with wrap.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {OW{1'b0}};
    cand_s  = {OW{1'b0}};
    hit_s   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s  = OW'((int'(ptr_r) + k) % NUM_REQ);
      hit_s   = req[cand_s] & ~found_s;
      pick_s  = hit_s ? cand_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  assign pick_data_s = req_data[DATA_W*int'(pick_s) +: DATA_W];

  // Pointer value after the current owner finishes: owner+1 wrapping at NUM_REQ.
  always_comb begin
    if (owner == OW'(NUM_REQ - 1)) begin
      nxt_ptr_s = {OW{1'b0}};
    end else begin
      nxt_ptr_s = owner + 1'b1;
    end
  end

  // Sequencer FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {OW{1'b0}};
      ack         <= {NUM_REQ{1'b0}};
      busy        <= 1'b0;
      owner       <= {OW{1'b0}};
      tx_start    <= 1'b0;
      tx_data     <= {DATA_W{1'b0}};
      timeout_err <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt_r  <= {CW{1'b0}};
`endif
    end else begin
      ack         <= {NUM_REQ{1'b0}};
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            owner   <= pick_s;
            tx_data <= pick_data_s;
            busy    <= 1'b1;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            state_r    <= ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
            wait_cnt_r <= {CW{1'b0}};
`endif
          end
        end
        ST_WAIT: begin
          // tx_done wins over a timeout landing on the same cycle.
          if (tx_done) begin
            ack[owner] <= 1'b1;
            ptr_r      <= nxt_ptr_s;
            state_r    <= ST_GAP;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            ptr_r       <= nxt_ptr_s;
            state_r     <= ST_GAP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
